// File: rtl/div_hilo_ctrl.sv
// div_hilo_ctrl: DIV/DIVU sequencer around a 32-cycle unsigned divider core; owns HI/LO (MTHI/MTLO).
// Optional build macro DIV_ZERO_FAST_EN: a zero divisor bypasses the core and finishes in two cycles.
module div_hilo_ctrl #(
   parameter int WIDTH    = 32,
   parameter int WATCHDOG = 40
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_valid,
   input  logic             req_signed,
   input  logic [WIDTH-1:0] rs,
   input  logic [WIDTH-1:0] rt,
   input  logic             mthi_we,
   input  logic             mtlo_we,
   output logic             stall,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_start,
   output logic [WIDTH-1:0] div_a,
   output logic [WIDTH-1:0] div_b,
   input  logic [WIDTH-1:0] div_q,
   input  logic [WIDTH-1:0] div_r,
   input  logic             div_busy,
   output logic             wd_err
);

   localparam int WDW = $clog2(WATCHDOG + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_WAIT  = 3'd2,
      S_FIX   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             sgnq_q, sgnq_d;
   logic             sgnr_q, sgnr_d;
   logic [WDW-1:0]   wd_cnt_q, wd_cnt_d;
   logic             wd_err_q, wd_err_d;
`ifdef DIV_ZERO_FAST_EN
   logic             zero_q, zero_d;
`endif

   function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] x);
      return (~x) + WIDTH'(1);
   endfunction

   // 0x8000_0000 maps onto itself, which the unsigned core reads as +2^31.
   function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] x);
      return (x < 0) ? neg2c(x) : x;
   endfunction

   function automatic logic [WIDTH-1:0] fix_sign(input logic [WIDTH-1:0] mag, input logic neg);
      return neg ? neg2c(mag) : mag;
   endfunction

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         hi_q     <= '0;
         lo_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         sgnq_q   <= 1'b0;
         sgnr_q   <= 1'b0;
         wd_cnt_q <= '0;
         wd_err_q <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
         zero_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sgnq_q   <= sgnq_d;
         sgnr_q   <= sgnr_d;
         wd_cnt_q <= wd_cnt_d;
         wd_err_q <= wd_err_d;
`ifdef DIV_ZERO_FAST_EN
         zero_q   <= zero_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      a_d      = a_q;
      b_d      = b_q;
      sgnq_d   = sgnq_q;
      sgnr_d   = sgnr_q;
      wd_cnt_d = wd_cnt_q;
      wd_err_d = wd_err_q;
`ifdef DIV_ZERO_FAST_EN
      zero_d   = zero_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               sgnq_d  = req_signed & (rs[WIDTH-1] ^ rt[WIDTH-1]);
               sgnr_d  = req_signed & rs[WIDTH-1];
               a_d     = req_signed ? abs_val(rs) : rs;
               b_d     = req_signed ? abs_val(rt) : rt;
               state_d = S_START;
`ifdef DIV_ZERO_FAST_EN
               zero_d  = (rt == '0);
               if (rt == '0) state_d = S_FIX;
`endif
            end else begin
               if (mthi_we) hi_d = rs;
               if (mtlo_we) lo_d = rs;
            end
         end
         S_START: begin
            wd_cnt_d = '0;
            state_d  = S_WAIT;
         end
         S_WAIT: begin
            // Core completion wins over a watchdog expiry landing in the same cycle.
            if (!div_busy) begin
               state_d = S_FIX;
            end else if (wd_cnt_q == WDW'(WATCHDOG - 1)) begin
               wd_err_d = 1'b1;
               state_d  = S_DONE;
            end else begin
               wd_cnt_d = wd_cnt_q + WDW'(1);
            end
         end
         S_FIX: begin
            lo_d    = fix_sign(div_q, sgnq_q);
            hi_d    = fix_sign(div_r, sgnr_q);
`ifdef DIV_ZERO_FAST_EN
            if (zero_q) begin
               lo_d = '1;
               hi_d = rs;
            end
`endif
            state_d = S_DONE;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign stall     = req_valid & (state_q != S_DONE);
   assign div_start = (state_q == S_START);
   assign hi        = hi_q;
   assign lo        = lo_q;
   assign div_a     = a_q;
   assign div_b     = b_q;
   assign wd_err    = wd_err_q;

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Self-checking bench for div_hilo_ctrl with a behavioural 32-cycle divider core model.
// Honors DIV_ZERO_FAST_EN when the build defines it.
module tb_div_hilo_ctrl;

   logic        clock, reset;
   logic        req_valid, req_signed, mthi_we, mtlo_we;
   logic [31:0] rs, rt;
   logic        stall, div_start, div_busy, wd_err;
   logic [31:0] hi, lo, div_a, div_b, div_q, div_r;

   int n_chk = 0;
   int n_fail = 0;

   // Core model state
   logic        core_busy, hang;
   logic [5:0]  core_cnt;
   logic [31:0] core_q, core_r;

   div_hilo_ctrl #(.WIDTH(32), .WATCHDOG(40)) dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_signed(req_signed),
      .rs(rs), .rt(rt), .mthi_we(mthi_we), .mtlo_we(mtlo_we), .stall(stall),
      .hi(hi), .lo(lo), .div_start(div_start), .div_a(div_a), .div_b(div_b),
      .div_q(div_q), .div_r(div_r), .div_busy(div_busy), .wd_err(wd_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Unsigned iterative core: busy from the edge sampling start, low after 32 iterations.
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         core_busy <= 1'b0;
         core_cnt  <= '0;
         core_q    <= '0;
         core_r    <= '0;
      end else if (div_start) begin
         core_busy <= 1'b1;
         core_cnt  <= 6'd31;
         core_q    <= (div_b == 0) ? 32'hFFFF_FFFF : div_a / div_b;
         core_r    <= (div_b == 0) ? div_a : div_a % div_b;
      end else if (core_busy && !hang) begin
         if (core_cnt == 6'd1) core_busy <= 1'b0;
         core_cnt <= core_cnt - 6'd1;
      end
   end
   assign div_busy = core_busy;
   assign div_q    = core_q;
   assign div_r    = core_r;

   function automatic void ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] eq, output logic [31:0] er);
      longint sa, sb;
      if (b == 0) begin
`ifdef DIV_ZERO_FAST_EN
         eq = 32'hFFFF_FFFF;
         er = a;
`else
         eq = (sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
         er = a;
`endif
      end else if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         eq = 32'(sa / sb);
         er = 32'(sa % sb);
      end else begin
         eq = a / b;
         er = a % b;
      end
   endfunction

   function automatic int ref_width(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
      if (b == 0) return 2;
`endif
      return 35;
   endfunction

   task automatic next_cyc();
      @(posedge clock);
      #1;
   endtask

   // Drives one request from an IDLE cycle; returns in the DONE cycle (stall low).
   task automatic do_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        output int width, output int starts, output bit done);
      req_valid = 1'b1; req_signed = sgn; rs = a; rt = b;
      width = 0; starts = 0; done = 1'b0;
      for (int i = 0; i < 200; i++) begin
         #1;
         if (div_start) starts++;
         if (!stall) begin
            done = 1'b1;
            break;
         end
         width++;
         @(posedge clock);
         #1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; req_valid = 0; req_signed = 0; rs = 0; rt = 0;
      mthi_we = 0; mtlo_we = 0; hang = 0;
      next_cyc(); next_cyc();
      n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
      n_chk++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi got %h want 0", hi); end
      n_chk++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo got %h want 0", lo); end
      n_chk++; if (div_start !== 1'b0) begin n_fail++; $display("FAIL reset_start got %b want 0", div_start); end
      n_chk++; if (div_a !== 32'd0 || div_b !== 32'd0) begin n_fail++; $display("FAIL reset_ab got %h/%h want 0/0", div_a, div_b); end
      n_chk++; if (wd_err !== 1'b0) begin n_fail++; $display("FAIL reset_wd got %b want 0", wd_err); end
      reset = 1'b1;
      next_cyc();
   endtask

   task automatic test_mthi_mtlo();
      rs = 32'hA5A5_A5A5; mthi_we = 1; next_cyc(); mthi_we = 0;
      n_chk++; if (hi !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL mthi got %h want a5a5a5a5", hi); end
      n_chk++; if (lo !== 32'd0) begin n_fail++; $display("FAIL mthi_lo got %h want 0", lo); end
      rs = 32'h5A5A_0001; mtlo_we = 1; next_cyc(); mtlo_we = 0;
      n_chk++; if (lo !== 32'h5A5A_0001) begin n_fail++; $display("FAIL mtlo got %h want 5a5a0001", lo); end
      rs = 32'h0000_1234; mthi_we = 1; mtlo_we = 1; next_cyc(); mthi_we = 0; mtlo_we = 0;
      n_chk++; if (hi !== 32'h1234 || lo !== 32'h1234) begin n_fail++; $display("FAIL mt_both got %h/%h want 1234/1234", hi, lo); end
   endtask

   task automatic test_divu_basic();
      int w, s; bit d;
      do_op(1'b0, 32'd100, 32'd7, w, s, d);
      n_chk++; if (d !== 1'b1) begin n_fail++; $display("FAIL divu_done got %b want 1", d); end
      n_chk++; if (w != 35) begin n_fail++; $display("FAIL divu_stall_width got %0d want 35", w); end
      n_chk++; if (s != 1) begin n_fail++; $display("FAIL divu_start_pulses got %0d want 1", s); end
      n_chk++; if (lo !== 32'd14 || hi !== 32'd2) begin n_fail++; $display("FAIL divu_result got lo=%h hi=%h want e/2", lo, hi); end
      n_chk++; if (div_a !== 32'd100 || div_b !== 32'd7) begin n_fail++; $display("FAIL divu_operands got %h/%h want 64/7", div_a, div_b); end
      next_cyc(); req_valid = 0;
   endtask

   task automatic test_div_signed();
      int w, s; bit d;
      do_op(1'b1, 32'hFFFF_FF9C, 32'd7, w, s, d);
      n_chk++; if (lo !== 32'hFFFF_FFF2 || hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL div_neg got lo=%h hi=%h want fffffff2/fffffffe", lo, hi); end
      n_chk++; if (div_a !== 32'd100) begin n_fail++; $display("FAIL div_neg_abs got %h want 64", div_a); end
      next_cyc(); req_valid = 0;
      do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, w, s, d);
      n_chk++; if (lo !== 32'h8000_0000 || hi !== 32'd0) begin n_fail++; $display("FAIL div_ovf got lo=%h hi=%h want 80000000/0", lo, hi); end
      n_chk++; if (wd_err !== 1'b0) begin n_fail++; $display("FAIL div_ovf_wd got %b want 0", wd_err); end
      next_cyc(); req_valid = 0;
   endtask

   task automatic test_div_zero();
      int w, s; bit d;
      do_op(1'b0, 32'd7, 32'd0, w, s, d);
      n_chk++; if (w != ref_width(32'd0)) begin n_fail++; $display("FAIL divz_width got %0d want %0d", w, ref_width(32'd0)); end
      n_chk++; if (hi !== 32'd7 || lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divz_result got hi=%h lo=%h want 7/ffffffff", hi, lo); end
      next_cyc(); req_valid = 0;
   endtask

   task automatic test_back_to_back();
      int w, s; bit d;
      logic [31:0] eq, er;
      do_op(1'b0, 32'd1000, 32'd33, w, s, d);
      next_cyc();
      do_op(1'b1, 32'hFFFF_FC18, 32'd33, w, s, d);
      ref_div(1'b1, 32'hFFFF_FC18, 32'd33, eq, er);
      n_chk++; if (!d || w != 35) begin n_fail++; $display("FAIL b2b_width got %0d want 35", w); end
      n_chk++; if (lo !== eq || hi !== er) begin n_fail++; $display("FAIL b2b_result got lo=%h hi=%h want %h/%h", lo, hi, eq, er); end
      next_cyc(); req_valid = 0;
   endtask

   task automatic test_random();
      int w, s; bit d, sg;
      logic [31:0] a, b, eq, er;
      for (int k = 0; k < 14; k++) begin
         sg = 1'($urandom_range(0, 1));
         a  = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = 32'hFFFF_FFFF;
            2: b = $urandom_range(1, 15);
            default: b = $urandom;
         endcase
         ref_div(sg, a, b, eq, er);
         do_op(sg, a, b, w, s, d);
         n_chk++; if (!d || w != ref_width(b)) begin n_fail++; $display("FAIL rand_width[%0d] got %0d want %0d", k, w, ref_width(b)); end
         n_chk++; if (lo !== eq || hi !== er) begin n_fail++; $display("FAIL rand_result[%0d] s=%0d a=%h b=%h got lo=%h hi=%h want %h/%h", k, sg, a, b, lo, hi, eq, er); end
         next_cyc(); req_valid = 0;
         if ($urandom_range(0, 1) == 1) next_cyc();
      end
   endtask

   task automatic test_watchdog();
      int w, s; bit d;
      rs = 32'h0BAD_F00D; mthi_we = 1; mtlo_we = 1; next_cyc(); mthi_we = 0; mtlo_we = 0;
      hang = 1;
      do_op(1'b1, 32'd50, 32'd3, w, s, d);
      n_chk++; if (d !== 1'b1 || w != 42) begin n_fail++; $display("FAIL wd_release done=%b width=%0d want 1/42", d, w); end
      n_chk++; if (wd_err !== 1'b1) begin n_fail++; $display("FAIL wd_flag got %b want 1", wd_err); end
      n_chk++; if (hi !== 32'h0BAD_F00D || lo !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL wd_hilo got %h/%h want 0badf00d", hi, lo); end
      next_cyc(); req_valid = 0; hang = 0;
      do_op(1'b0, 32'd90, 32'd9, w, s, d);
      n_chk++; if (lo !== 32'd10 || hi !== 32'd0 || wd_err !== 1'b1) begin n_fail++; $display("FAIL wd_sticky got lo=%h hi=%h wd=%b want a/0/1", lo, hi, wd_err); end
      next_cyc(); req_valid = 0;
   endtask

   task automatic test_reset_mid();
      int w, s; bit d;
      req_valid = 1; req_signed = 0; rs = 32'd500; rt = 32'd5;
      for (int i = 0; i < 10; i++) next_cyc();
      reset = 1'b0; req_valid = 0;
      #1;
      n_chk++; if (stall !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL midreset got stall=%b hi=%h lo=%h want 0/0/0", stall, hi, lo); end
      n_chk++; if (wd_err !== 1'b0 || div_a !== 32'd0) begin n_fail++; $display("FAIL midreset_regs got wd=%b a=%h want 0/0", wd_err, div_a); end
      next_cyc(); reset = 1'b1; next_cyc();
      do_op(1'b1, 32'hFFFF_FF9C, 32'd7, w, s, d);
      n_chk++; if (w != 35 || lo !== 32'hFFFF_FFF2 || hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL post_reset_div got w=%0d lo=%h hi=%h want 35/fffffff2/fffffffe", w, lo, hi); end
      next_cyc(); req_valid = 0;
   endtask

   initial begin
      test_reset();
      test_mthi_mtlo();
      test_divu_basic();
      test_div_signed();
      test_div_zero();
      test_back_to_back();
      test_random();
      test_watchdog();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
